ascon_permutation_engine: RTL and testbench

//  Iterative Ascon permutation core (p^a/p^b) with run-time round count (12/8/6).

---
 rtl/ascon_permutation_engine.sv | 158 +++++++++++++++
 tb/tb_ascon_permutation_engine.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_permutation_engine.sv
// Iterative Ascon permutation (p12/p8/p6), UNROLL rounds per clock, self-generated round constants.
// Latency ceil(nr/UNROLL)+1 cycles from accept to out_valid; optional abort port when ASCON_PERM_ABORT_EN is defined.
module ascon_permutation_engine #(
   parameter int UNROLL = 1
) (
   input  logic         clk,
   input  logic         nRST,
`ifdef ASCON_PERM_ABORT_EN
   input  logic         abort,
`endif
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   in_mode,
   input  logic [319:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [319:0] out_state,
   output logic         busy
);

   if (UNROLL < 1 || UNROLL > 6) begin : g_bad_unroll
      $error("ascon_permutation_engine: UNROLL must be in 1..6");
   end

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]   fsm_q, fsm_d;
   logic [319:0] state_q, state_d;
   logic [4:0]   rc_idx_q, rc_idx_d;
   logic [4:0]   rc_nxt;
   logic [4:0]   rnd;
   logic [319:0] chain;
   logic [4:0]   rc_start;
   logic         abort_w;

   function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // One full Ascon round: constant addition, bitsliced S-box, linear diffusion.
   function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] c);
      logic [63:0] x0, x1, x2, x3, x4;
      logic [63:0] t0, t1, t2, t3, t4;
      x0 = s[319:256];
      x1 = s[255:192];
      x2 = s[191:128] ^ {56'd0, c};
      x3 = s[127:64];
      x4 = s[63:0];
      x0 = x0 ^ x4;
      x4 = x4 ^ x3;
      x2 = x2 ^ x1;
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 = x0 ^ t1;
      x1 = x1 ^ t2;
      x2 = x2 ^ t3;
      x3 = x3 ^ t4;
      x4 = x4 ^ t0;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      x2 = ~x2;
      x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
      x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
      x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
      x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
      x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
      return {x0, x1, x2, x3, x4};
   endfunction

`ifdef ASCON_PERM_ABORT_EN
   assign abort_w = abort & (fsm_q != S_IDLE);
`else
   assign abort_w = 1'b0;
`endif

   // Rounds past index 11 in the last unrolled cycle pass the state through untouched.
   always_comb begin
      rnd   = '0;
      chain = state_q;
      for (int k = 0; k < UNROLL; k++) begin
         rnd = rc_idx_q + 5'(k);
         if (rnd < 5'd12) begin
            chain = ascon_round(chain, {~rnd[3:0], rnd[3:0]});
         end
      end
   end

   always_comb begin
      case (in_mode)
         2'b01:   rc_start = 5'd4;
         2'b10:   rc_start = 5'd6;
         default: rc_start = 5'd0;
      endcase
   end

   assign rc_nxt = rc_idx_q + 5'(UNROLL);

   always_comb begin
      fsm_d    = fsm_q;
      state_d  = state_q;
      rc_idx_d = rc_idx_q;
      case (fsm_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d  = in_state;
               rc_idx_d = rc_start;
               fsm_d    = S_RUN;
            end
         end
         S_RUN: begin
            state_d  = chain;
            rc_idx_d = rc_nxt;
            if (rc_nxt >= 5'd12) fsm_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               if (in_valid) begin
                  state_d  = in_state;
                  rc_idx_d = rc_start;
                  fsm_d    = S_RUN;
               end else begin
                  fsm_d = S_IDLE;
               end
            end
         end
         default: fsm_d = S_IDLE;
      endcase
      if (abort_w) begin
         fsm_d    = S_IDLE;
         state_d  = '0;
         rc_idx_d = '0;
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         fsm_q    <= S_IDLE;
         state_q  <= '0;
         rc_idx_q <= '0;
      end else begin
         fsm_q    <= fsm_d;
         state_q  <= state_d;
         rc_idx_q <= rc_idx_d;
      end
   end

   assign in_ready  = (fsm_q == S_IDLE) | ((fsm_q == S_DONE) & out_ready & ~abort_w);
   assign out_valid = (fsm_q == S_DONE);
   assign busy      = (fsm_q == S_RUN);
   assign out_state = state_q;

endmodule

// File: tb/tb_ascon_permutation_engine.sv
// Scoreboard bench: UNROLL=1 and UNROLL=4 engines, expected results from a table-driven Ascon model.
module tb_ascon_permutation_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  nRST;
   logic [1:0]            in_valid, in_ready, out_valid, out_ready, busy;
   logic [1:0][1:0]       in_mode;
   logic [1:0][319:0]     in_state, out_state;
`ifdef ASCON_PERM_ABORT_EN
   logic [1:0]            abort;
`endif

   ascon_permutation_engine #(.UNROLL(1)) dut (
      .clk(clk), .nRST(nRST),
`ifdef ASCON_PERM_ABORT_EN
      .abort(abort[0]),
`endif
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_mode(in_mode[0]), .in_state(in_state[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_state(out_state[0]), .busy(busy[0])
   );

   ascon_permutation_engine #(.UNROLL(4)) dut4 (
      .clk(clk), .nRST(nRST),
`ifdef ASCON_PERM_ABORT_EN
      .abort(abort[1]),
`endif
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_mode(in_mode[1]), .in_state(in_state[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_state(out_state[1]), .busy(busy[1])
   );

   typedef struct {
      int           inst;
      logic [319:0] st;
      int           acc;
      int           lat;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   passes = 0;
   int   cyc = 0;
   int   busy_cnt[2];
   logic [1:0] seen;
   logic       ign = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic logic [63:0] rr(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // Reference permutation using the 5-bit S-box lookup table applied column by column.
   function automatic logic [319:0] model(input logic [319:0] s, input int nr);
      logic [63:0] x[5];
      logic [63:0] y[5];
      logic [4:0]  tab[32];
      logic [4:0]  v, o;
      logic [3:0]  r4;
      tab = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
              5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
              5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
              5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
      for (int i = 0; i < 5; i++) x[i] = s[319 - 64 * i -: 64];
      for (int r = 12 - nr; r < 12; r++) begin
         r4 = 4'(r);
         x[2][7:0] = x[2][7:0] ^ {~r4, r4};
         for (int b = 0; b < 64; b++) begin
            v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            o = tab[v];
            for (int i = 0; i < 5; i++) y[i][b] = o[4 - i];
         end
         x[0] = y[0] ^ rr(y[0], 19) ^ rr(y[0], 28);
         x[1] = y[1] ^ rr(y[1], 61) ^ rr(y[1], 39);
         x[2] = y[2] ^ rr(y[2], 1)  ^ rr(y[2], 6);
         x[3] = y[3] ^ rr(y[3], 10) ^ rr(y[3], 17);
         x[4] = y[4] ^ rr(y[4], 7)  ^ rr(y[4], 41);
      end
      return {x[0], x[1], x[2], x[3], x[4]};
   endfunction

   // Monitor: checks latency, RUN-cycle count and result whenever an engine presents output.
   always @(negedge clk) begin
      if (!nRST) begin
         seen = '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (busy[i]) busy_cnt[i]++;
            if (out_valid[i] && !ign) begin
               if (sbq.size() == 0 || sbq[0].inst != i) begin
                  chk_int("unexpected_out_valid", int'(out_valid[i]), 0);
               end else begin
                  if (!seen[i]) begin
                     seen[i] = 1'b1;
                     chk_int("latency", cyc - sbq[0].acc, sbq[0].lat);
                     chk_int("busy_cycles", busy_cnt[i], sbq[0].lat - 1);
                  end
                  if (out_ready[i]) begin
                     chk("result", out_state[i], sbq[0].st);
                     void'(sbq.pop_front());
                     seen[i] = 1'b0;
                  end
               end
            end
            if (in_valid[i] && in_ready[i]) busy_cnt[i] = 0;
         end
      end
   end

   task automatic issue(input int i, input logic [1:0] m, input logic [319:0] s);
      int   nr;
      int   u;
      exp_t e;
      logic got;
      nr  = (m == 2'b01) ? 8 : (m == 2'b10) ? 6 : 12;
      u   = (i == 0) ? 1 : 4;
      got = 1'b0;
      in_mode[i]  = m;
      in_state[i] = s;
      in_valid[i] = 1'b1;
      for (int t = 0; t < 200 && !got; t++) begin
         @(negedge clk);
         if (in_ready[i]) begin
            e.inst = i;
            e.st   = model(s, nr);
            e.acc  = cyc;
            e.lat  = (nr + u - 1) / u + 1;
            sbq.push_back(e);
            got = 1'b1;
         end
      end
      if (!got) chk_int("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid[i] = 1'b0;
      in_mode[i]  = ~m;
      in_state[i] = ~s;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sbq.size() != 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      chk_int("drain_pending", sbq.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out_valid(input int i);
      int t;
      t = 0;
      @(negedge clk);
      while (!out_valid[i] && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk_int("out_valid_timeout", int'(out_valid[i]), 1);
   endtask

   logic [319:0] va, vb, vc, held;

   initial begin
      va = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978,
            64'h8796a5b4c3d2e1f0, 64'hdeadbeefcafef00d};
      vb = {64'h00400c0000000100, 64'h0, 64'h0, 64'h0, 64'h0};
      vc = {64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333,
            64'h4444444444444444, 64'h5555555555555555};
      nRST      = 1'b0;
      in_valid  = '0;
      in_mode   = '0;
      in_state  = '0;
      out_ready = '1;
      busy_cnt  = '{0, 0};
      seen      = '0;
`ifdef ASCON_PERM_ABORT_EN
      abort     = '0;
`endif
      #1;
      chk_int("rst_out_valid", int'(out_valid), 0);
      chk_int("rst_busy", int'(busy), 0);
      chk_int("rst_in_ready", int'(in_ready), 3);
      chk("rst_state", out_state[0], '0);
      #21;
      nRST = 1'b1;
      @(posedge clk);
      #1;

      // p12 on the Ascon-128 initialisation state, then p6/p8/reserved back to back
      issue(0, 2'b00, {64'h80400c0600000000, 256'd0});
      drain();
      issue(0, 2'b10, va);
      issue(0, 2'b01, va);
      issue(0, 2'b11, vb);
      drain();

      // UNROLL=4: p6 in two RUN cycles, then p12 and p8
      issue(1, 2'b10, va);
      issue(1, 2'b00, {64'h80400c0600000000, 256'd0});
      issue(1, 2'b01, vc);
      drain();

      // Backpressure: result held for several cycles, then retire-and-accept in one cycle
      out_ready[0] = 1'b0;
      issue(0, 2'b00, vc);
      wait_out_valid(0);
      held = out_state[0];
      @(posedge clk);
      #1;
      in_mode[0]  = 2'b00;
      in_state[0] = vb;
      in_valid[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_state_stable", out_state[0], held);
         chk_int("stall_in_ready", int'(in_ready[0]), 0);
      end
      @(posedge clk);
      #1;
      out_ready[0] = 1'b1;
      issue(0, 2'b00, vb);
      drain();

      // Asynchronous reset in the third RUN cycle
      issue(0, 2'b00, va);
      @(posedge clk);
      @(posedge clk);
      #2;
      nRST = 1'b0;
      #1;
      chk_int("midrun_rst_out_valid", int'(out_valid[0]), 0);
      chk_int("midrun_rst_busy", int'(busy[0]), 0);
      chk_int("midrun_rst_in_ready", int'(in_ready[0]), 1);
      chk("midrun_rst_state", out_state[0], '0);
      sbq.delete();
      #3;
      nRST = 1'b1;
      @(posedge clk);
      #1;
      issue(0, 2'b01, vc);
      drain();

`ifdef ASCON_PERM_ABORT_EN
      ign = 1'b1;
      issue(0, 2'b00, va);
      sbq.delete();
      repeat (3) @(posedge clk);
      #1;
      abort[0] = 1'b1;
      @(posedge clk);
      #1;
      abort[0] = 1'b0;
      @(negedge clk);
      chk_int("abort_run_busy", int'(busy[0]), 0);
      chk_int("abort_run_out_valid", int'(out_valid[0]), 0);
      chk("abort_run_state", out_state[0], '0);
      out_ready[0] = 1'b0;
      issue(0, 2'b10, vb);
      sbq.delete();
      wait_out_valid(0);
      @(posedge clk);
      #1;
      abort[0]     = 1'b1;
      out_ready[0] = 1'b1;
      in_mode[0]   = 2'b00;
      in_state[0]  = vc;
      in_valid[0]  = 1'b1;
      @(negedge clk);
      chk_int("abort_done_in_ready", int'(in_ready[0]), 0);
      @(posedge clk);
      #1;
      abort[0]    = 1'b0;
      in_valid[0] = 1'b0;
      @(negedge clk);
      chk_int("abort_done_out_valid", int'(out_valid[0]), 0);
      chk_int("abort_done_busy", int'(busy[0]), 0);
      @(posedge clk);
      #1;
      ign = 1'b0;
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got %0d/%0d", passes, checks);
      $fatal(1);
   end

endmodule
